// File: rtl/rsadd_ctl.sv
// rsadd_ctl: sequencer for the right-shift/add alignment datapath (one pass sp, two passes dp).
// Optional completed-op counter enabled by defining RSADD_CTL_OPCNT_EN.
module rsadd_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dp,
  input  logic [5:0]       shamt,
  input  logic             cin,
  input  logic             hold,
  input  logic             kill,
  input  logic             a0zero,
  input  logic             sticky,
  input  logic             rsovfi,
  output logic [1:0]       r0md,
  output logic [1:0]       r1md,
  output logic [4:0]       saout,
  output logic [1:0]       bsmd,
  output logic             aqcin,
  output logic             stin,
  output logic             lo_we,
  output logic             hi_we,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic             sticky_out,
  output logic [CNT_W-1:0] opcnt
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state_q, state_d;
  logic dp_q, dp_d, cin_q, cin_d, carry_q, carry_d, stk_q, stk_d, cout_q, cout_d;
  logic [5:0] s_q, s_d;
  logic lo, hi;
  always_comb begin
    state_d = state_q;
    dp_d    = dp_q;
    s_d     = s_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    stk_d   = stk_q;
    cout_d  = cout_q;
    if (kill) state_d = IDLE;
    else if (!hold) begin
      case (state_q)
        LO: begin
          state_d = dp_q ? HI : DONE;
          carry_d = rsovfi;
          stk_d   = sticky | (s_q[5] & ~a0zero);
          cout_d  = rsovfi;
        end
        HI: begin
          state_d = DONE;
          cout_d  = rsovfi;
        end
        default: begin
          state_d = start ? LO : IDLE;
          dp_d    = start ? dp : dp_q;
          s_d     = start ? shamt : s_q;
          cin_d   = start ? cin : cin_q;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dp_q    <= 1'b0;
      s_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      stk_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
      s_q     <= s_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      stk_q   <= stk_d;
      cout_q  <= cout_d;
    end
  end
  // Outputs are a pure decode of registered state; only the write enables see hold.
  always_comb begin
    lo         = state_q == LO;
    hi         = state_q == HI;
    r0md       = lo ? (s_q[5] ? (dp_q ? 2'd1 : 2'd2) : 2'd0) : hi ? (s_q[5] ? 2'd2 : 2'd1) : 2'd2;
    r1md       = (lo && dp_q && !s_q[5]) ? 2'd0 : 2'd2;
    saout      = (lo || hi) ? s_q[4:0] : 5'd0;
    bsmd       = lo ? 2'd1 : hi ? 2'd2 : 2'd0;
    aqcin      = lo ? cin_q : hi ? carry_q : 1'b0;
    stin       = 1'b0;
    lo_we      = lo & ~hold;
    hi_we      = hi & ~hold;
    busy       = lo | hi;
    done       = state_q == DONE;
    cout       = done & cout_q;
    sticky_out = done & stk_q;
  end
`ifdef RSADD_CTL_OPCNT_EN
  logic [CNT_W-1:0] opcnt_q, opcnt_d;
  always_comb opcnt_d = (done && !hold && opcnt_q != '1) ? opcnt_q + CNT_W'(1) : opcnt_q;
  always_ff @(posedge clk) begin
    if (reset) opcnt_q <= '0;
    else opcnt_q <= opcnt_d;
  end
  assign opcnt = opcnt_q;
`else
  assign opcnt = '0;
`endif
endmodule

// File: tb/tb_rsadd_ctl.sv
// tb_rsadd_ctl: directed table, corner-case sequences and random traffic against a pass-queue model.
module tb_rsadd_ctl;
  localparam int CNT_W = 2;
`ifdef RSADD_CTL_OPCNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic start = 0, dp = 0, cin = 0, hold = 0, kill = 0, a0zero = 0, sticky = 0, rsovfi = 0;
  logic [5:0] shamt = '0;
  logic [1:0] r0md, r1md, bsmd;
  logic [4:0] saout;
  logic aqcin, stin, lo_we, hi_we, busy, done, cout, sticky_out;
  logic [CNT_W-1:0] opcnt;
  rsadd_ctl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst), .start(start), .dp(dp), .shamt(shamt), .cin(cin), .hold(hold),
    .kill(kill), .a0zero(a0zero), .sticky(sticky), .rsovfi(rsovfi), .r0md(r0md), .r1md(r1md),
    .saout(saout), .bsmd(bsmd), .aqcin(aqcin), .stin(stin), .lo_we(lo_we), .hi_we(hi_we),
    .busy(busy), .done(done), .cout(cout), .sticky_out(sticky_out), .opcnt(opcnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic start, dp;
    logic [5:0] shamt;
    logic cin, hold, kill, a0zero, sticky, rsovfi;
    logic [18:0] exp;
  } vec_t;
  int checks = 0, errors = 0;
  logic [18:0] got;
  // Model: queue of pending cycle kinds for the current op (1 low pass, 2 high pass, 3 done).
  int q[$];
  logic m_dp, m_cin, m_carry, m_stk, m_cout;
  logic [5:0] m_s;
  int cnt = 0;
  function automatic logic [18:0] mk(int r0, int r1, int sa, int bs, int aq, int lw, int hw,
                                      int bu, int dn, int co, int st);
    return {r0[1:0], r1[1:0], sa[4:0], bs[1:0], aq[0], 1'b0, lw[0], hw[0], bu[0], dn[0], co[0], st[0]};
  endfunction
  function automatic vec_t vi(int st, int d, int sh, int ci, int ho, int ki, int az, int sk,
                              int ro, logic [18:0] e);
    return {st[0], d[0], sh[5:0], ci[0], ho[0], ki[0], az[0], sk[0], ro[0], e};
  endfunction
  function automatic logic [18:0] model_out();
    int r0lo[4] = '{0, 2, 0, 1};
    int head = q.size() ? q[0] : 0;
    if (head == 1)
      return mk(r0lo[{m_dp, m_s[5]}], (m_dp && !m_s[5]) ? 0 : 2, int'(m_s[4:0]), 1, int'(m_cin),
                int'(!hold), 0, 1, 0, 0, 0);
    if (head == 2)
      return mk(m_s[5] ? 2 : 1, 2, int'(m_s[4:0]), 2, int'(m_carry), 0, int'(!hold), 1, 0, 0, 0);
    if (head == 3) return mk(2, 2, 0, 0, 0, 0, 0, 0, 1, int'(m_cout), int'(m_stk));
    return mk(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  task automatic model_step();
    int head = q.size() ? q[0] : 0;
    if (rst) begin
      q.delete();
      cnt = 0;
      return;
    end
    if (head == 3 && !hold && cnt < (1 << CNT_W) - 1) cnt++;
    if (kill) q.delete();
    else if (!hold) begin
      if (head == 1) begin
        m_carry = rsovfi;
        m_stk = sticky | (m_s[5] & ~a0zero);
        if (!m_dp) m_cout = rsovfi;
        void'(q.pop_front());
      end else if (head == 2) begin
        m_cout = rsovfi;
        void'(q.pop_front());
      end else if (start) begin
        m_dp = dp; m_s = shamt; m_cin = cin;
        q.delete();
        q.push_back(1);
        if (dp) q.push_back(2);
        q.push_back(3);
      end else if (head == 3) void'(q.pop_front());
    end
  endtask
  task automatic chk(string name, logic [31:0] g, logic [31:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, g, w, $time);
    end
  endtask
  task automatic step(vec_t v, bit use_tbl, string name);
    {start, dp, shamt, cin, hold, kill, a0zero, sticky, rsovfi} =
      {v.start, v.dp, v.shamt, v.cin, v.hold, v.kill, v.a0zero, v.sticky, v.rsovfi};
    @(negedge clk);
    got = {r0md, r1md, saout, bsmd, aqcin, stin, lo_we, hi_we, busy, done, cout, sticky_out};
    chk({name, " model"}, 32'(got), 32'(model_out()));
    if (use_tbl) chk({name, " table"}, 32'(got), 32'(v.exp));
    chk({name, " opcnt"}, 32'(opcnt), EN ? 32'(cnt) : 32'd0);
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
  endtask
  vec_t tbl[14];
  vec_t t;
  int hp, dc;
  initial begin
    logic [18:0] idl, dn0;
    idl = mk(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dn0 = mk(2, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[0]  = vi(1, 0, 5, 0, 0, 0, 1, 0, 0, idl);
    tbl[1]  = vi(0, 0, 0, 0, 0, 0, 1, 0, 0, mk(0, 2, 5, 1, 0, 1, 0, 1, 0, 0, 0));
    tbl[2]  = vi(0, 0, 0, 0, 0, 0, 1, 0, 0, dn0);
    tbl[3]  = vi(0, 0, 0, 0, 0, 0, 1, 0, 0, idl);
    tbl[4]  = vi(1, 1, 3, 1, 0, 0, 1, 0, 0, idl);
    tbl[5]  = vi(0, 0, 0, 0, 0, 0, 1, 0, 1, mk(0, 0, 3, 1, 1, 1, 0, 1, 0, 0, 0));
    tbl[6]  = vi(0, 0, 0, 0, 0, 0, 1, 1, 1, mk(1, 2, 3, 2, 1, 0, 1, 1, 0, 0, 0));
    tbl[7]  = vi(0, 0, 0, 0, 0, 0, 1, 0, 0, mk(2, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl[8]  = vi(0, 0, 0, 0, 0, 0, 1, 0, 0, idl);
    tbl[9]  = vi(1, 1, 40, 0, 0, 0, 0, 0, 0, idl);
    tbl[10] = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(1, 2, 8, 1, 0, 1, 0, 1, 0, 0, 0));
    tbl[11] = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2, 2, 8, 2, 0, 0, 1, 1, 0, 0, 0));
    tbl[12] = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl[13] = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, idl);
    do_reset();
    for (int i = 0; i < 14; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));
    // Hold two cycles in the high pass: one hi_we pulse, done two cycles late.
    t = vi(1, 1, 3, 0, 0, 0, 1, 0, 0, idl);
    step(t, 1'b0, "hold start");
    t.start = 0; hp = 0; dc = -1;
    for (int i = 1; i <= 6; i++) begin
      t.hold = (i == 2 || i == 3);
      step(t, 1'b0, "hold seq");
      hp += int'(got[4]);
      if (got[2] && dc < 0) dc = i;
    end
    chk("hold hi_we pulses", 32'(hp), 32'd1);
    chk("hold done cycle", 32'(dc), 32'd5);
    // Kill in the high pass, then a start during done goes straight to a low pass.
    t = vi(1, 1, 7, 0, 0, 0, 1, 0, 0, idl);
    step(t, 1'b0, "kill start");
    t.start = 0;
    step(t, 1'b0, "kill lo");
    t.kill = 1;
    step(t, 1'b0, "kill hi");
    t = vi(1, 0, 9, 1, 0, 0, 1, 0, 1, idl);
    step(t, 1'b0, "kill after");
    chk("kill idle", 32'(got), 32'(idl));
    t.start = 0;
    step(t, 1'b0, "b2b lo");
    t = vi(1, 0, 2, 0, 0, 0, 1, 0, 0, idl);
    step(t, 1'b0, "b2b done");
    chk("b2b done seen", 32'(got[2]), 32'd1);
    t.start = 0;
    step(t, 1'b0, "b2b relo");
    chk("b2b lo_we busy", 32'({got[5], got[3]}), 32'd3);
    step(t, 1'b0, "b2b done2");
    step(t, 1'b0, "b2b idle");
    // Five ops from reset: counter saturates at its max.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      t = vi(1, 0, k, 0, 0, 0, 1, 0, 0, idl);
      step(t, 1'b0, "sat start");
      t.start = 0;
      step(t, 1'b0, "sat lo");
    end
    step(t, 1'b0, "sat tail");
    chk("opcnt saturated", 32'(opcnt), EN ? 32'd3 : 32'd0);
    do_reset();
    #1;
    chk("opcnt reset", 32'(opcnt), 32'd0);
    for (int i = 0; i < 400; i++) begin
      t.start  = $urandom_range(0, 1);
      t.dp     = $urandom_range(0, 1);
      t.shamt  = 6'($urandom);
      t.cin    = $urandom_range(0, 1);
      t.hold   = $urandom_range(0, 6) == 0;
      t.kill   = $urandom_range(0, 19) == 0;
      t.a0zero = $urandom_range(0, 1);
      t.sticky = $urandom_range(0, 1);
      t.rsovfi = $urandom_range(0, 1);
      step(t, 1'b0, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
